ram_dados_ctrl: RTL and testbench
=================================

RAM_DADOS_CTRL -- requirements
Module: ram_dados_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: word-address bits; depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 1: extra cycles per access, legal range 0..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the posedge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: request present.
REQ-006 SHALL have port req_ready, output, 1: request accepted when req_valid && req_ready at a posedge.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned, input, 1: 1 = zero-extend load, 0 = sign-extend load.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH+2: byte address.
REQ-011 SHALL have port req_wdata, input, 32: store data, right-aligned in bits [7:0]/[15:0]/[31:0].
REQ-012 SHALL have port rsp_valid, output, 1: response present.
REQ-013 SHALL have port rsp_ready, input, 1: response consumed when rsp_valid && rsp_ready at a posedge.
REQ-014 SHALL have port rsp_rdata, output, 32: extended load data; 0 for stores.
REQ-015 SHALL have port rsp_err, output, 1: access fault flag, valid with rsp_valid.

Function
REQ-016 SHALL use FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE, rsp_valid = 1 only in RESP.
REQ-017 On acceptance SHALL register all req_* fields; go to WAIT with counter = WAIT_STATES-1, or directly to RESP when WAIT_STATES = 0.
REQ-018 In WAIT SHALL decrement the counter each cycle and go to RESP on the edge where it is 0.
REQ-019 SHALL perform the array write and register the read data on the edge that enters RESP; rsp_valid therefore rises WAIT_STATES+1 cycles after the acceptance edge.
REQ-020 In RESP SHALL hold rsp_rdata and rsp_err stable until the handshake, then return to IDLE; the next request is accepted no earlier than the following edge, giving throughput of one access per WAIT_STATES+2 cycles.
REQ-021 Byte lanes SHALL be little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-022 Stores SHALL modify only the addressed byte lanes; all other bytes are unchanged.
REQ-023 Loads SHALL extract the addressed lane and extend it to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-024 Word address SHALL be addr[ADDR_WIDTH+1:2], with no wrap beyond the array.
REQ-025 Array contents SHALL initialise to all-zero at time 0 and are not cleared by rst_n.

Reset
REQ-026 While rst_n = 0: state = IDLE, counter = 0, req_ready = 1 after release, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-027 Reset asserted in WAIT SHALL drop the pending access (no write performed); reset in RESP SHALL discard the response; memory contents are retained.

Configuration
REQ-028 With RAM_DADOS_ALIGN_CHECK_EN defined, a half access with addr[0] = 1, a word access with addr[1:0] != 0, or size 11 SHALL suppress the write and respond with rsp_err = 1 and rsp_rdata = 0 after normal latency.
REQ-029 Without RAM_DADOS_ALIGN_CHECK_EN, low address bits SHALL be masked to natural alignment, size 11 SHALL be treated as word, and rsp_err SHALL be tied to 0.

Structure
REQ-030 Package ram_dados_pkg SHALL hold the size encoding constants, the FSM state typedef, and the lane-extract and extend function.
REQ-031 Sub-module ram_dados_array SHALL hold the 2**ADDR_WIDTH x 32 storage, with a 4-bit byte write enable, synchronous posedge write, and combinational read.

Verification
REQ-032 WAIT_STATES = 1: store word 0xDEADBEEF at 0x08, then load word at 0x08 -> rsp_rdata = 0xDEADBEEF, rsp_valid 2 cycles after each acceptance.
REQ-033 Store byte 0x80 at 0x09, then load byte 0x09 signed -> 0xFFFFFF80 and unsigned -> 0x00000080; word at 0x08 reads 0xDEAD80EF.
REQ-034 Store half 0x1234 at 0x0E, then load word at 0x0C -> upper half = 0x1234, lower half unchanged.
REQ-035 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_rdata/rsp_err stable and req_ready = 0 throughout; no second acceptance occurs.
REQ-036 With RAM_DADOS_ALIGN_CHECK_EN: store word at 0x02 -> rsp_err = 1 and memory unchanged; without the macro -> write lands at 0x00 and rsp_err = 0.
REQ-037 Assert rst_n = 0 in WAIT of a store to 0x10 -> word at 0x10 unchanged, rsp_valid = 0, and req_ready = 1 after release.

Source files
------------

// File: rtl/ram_dados_pkg.sv
// Shared definitions for the ram_dados data-memory controller: size encodings,
// FSM state type and the load lane-extract/extend helper.
package ram_dados_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Pick the addressed lane out of a 32-bit word and extend it to 32 bits.
  function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: lane_extend = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_HALF: lane_extend = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
      default:   lane_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/ram_dados_array.sv
// 2**ADDR_WIDTH x 32 storage with per-byte write enable, synchronous write
// and combinational read.
module ram_dados_array #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // NOTE: storage has no reset -- contents start at zero and survive rst_n.
  logic [31:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ram_dados_ctrl.sv
// Load/store controller for the ram_dados array: valid/ready request and
// response channels with WAIT_STATES extra cycles per access.
// Optional misalignment faulting when RAM_DADOS_ALIGN_CHECK_EN is defined.
module ram_dados_ctrl
  import ram_dados_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int AW2    = ADDR_WIDTH + 2;
  localparam bit BYPASS = (WAIT_STATES == 0);

  state_t         state;
  logic [3:0]     cnt;
  logic           we_q;
  logic [1:0]     size_q;
  logic           uns_q;
  logic [AW2-1:0] addr_q;
  logic [31:0]    wdata_q;

  logic           accept;
  logic           enter_resp;
  logic           cur_we;
  logic           cur_uns;
  logic           cur_err;
  logic [1:0]     cur_size;
  logic [1:0]     eff_size;
  logic [1:0]     lane;
  logic [AW2-1:0] cur_addr;
  logic [31:0]    cur_wdata;
  logic [3:0]     lane_be;
  logic [31:0]    lane_wdata;
  logic [3:0]     arr_be;
  logic [31:0]    arr_rdata;

  assign accept = req_valid && req_ready;

  // With zero wait states the access completes on the acceptance edge, so the
  // live request fields drive the array; otherwise the registered copy does.
  assign cur_we    = (state == IDLE) ? req_we       : we_q;
  assign cur_size  = (state == IDLE) ? req_size     : size_q;
  assign cur_uns   = (state == IDLE) ? req_unsigned : uns_q;
  assign cur_addr  = (state == IDLE) ? req_addr     : addr_q;
  assign cur_wdata = (state == IDLE) ? req_wdata    : wdata_q;

  assign enter_resp = (accept && BYPASS) || (state == WAIT && cnt == 4'd0);
  assign eff_size   = (cur_size == SIZE_RSVD) ? SIZE_WORD : cur_size;

`ifdef RAM_DADOS_ALIGN_CHECK_EN
  assign cur_err = (cur_size == SIZE_RSVD) ||
                   (cur_size == SIZE_HALF && cur_addr[0]) ||
                   (cur_size == SIZE_WORD && cur_addr[1:0] != 2'b00);
`else
  assign cur_err = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lane       = 2'b00;
    lane_be    = 4'b1111;
    lane_wdata = cur_wdata;
    case (eff_size)
      SIZE_BYTE: begin
        lane       = cur_addr[1:0];
        lane_be    = 4'b0001 << cur_addr[1:0];
        lane_wdata = {4{cur_wdata[7:0]}};
      end
      SIZE_HALF: begin
        lane       = {cur_addr[1], 1'b0};
        lane_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign arr_be = (enter_resp && cur_we && !cur_err) ? lane_be : 4'b0000;

  ram_dados_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .addr  (cur_addr[AW2-1:2]),
    .be    (arr_be),
    .wdata (lane_wdata),
    .rdata (arr_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= SIZE_BYTE;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
    end else begin
      if (enter_resp) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_we || cur_err) ? 32'd0
                   : lane_extend(arr_rdata, eff_size, lane, cur_uns);
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (!BYPASS) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dados_ctrl.sv
// Self-checking bench for ram_dados_ctrl: directed scenarios plus random
// loads/stores compared against a byte-array reference model.
module tb_ram_dados_ctrl;

  localparam int ADDR_WIDTH  = 5;
  localparam int WAIT_STATES = 1;
  localparam int NBYTES      = 4 * (2 ** ADDR_WIDTH);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [NBYTES];

  always #5 clk = ~clk;

  ram_dados_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .WAIT_STATES(WAIT_STATES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] size);
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit faulty(input logic [1:0] size, input int addr);
`ifdef RAM_DADOS_ALIGN_CHECK_EN
    return (size == 2'b11) || (addr % size_bytes(size) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Model: apply the access to the byte array and return the expected response.
  task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                              input int addr, input logic [31:0] wdata,
                              output logic [31:0] exp_rdata, output logic exp_err);
    int n, base;
    logic [31:0] v;
    n         = size_bytes(size);
    base      = addr - (addr % n);
    exp_err   = faulty(size, addr);
    exp_rdata = 32'd0;
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < n; i++) model[base + i] = 8'(wdata >> (8 * i));
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(model[base + i]) << (8 * i));
        if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        exp_rdata = v;
      end
    end
  endtask

  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input int addr, input logic [31:0] wdata, input int hold);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          guard;
    model_access(we, size, uns, addr, wdata, exp_rdata, exp_err);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = 7'(addr);
    req_wdata    = wdata;
    guard        = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", 32'(lat), 32'(WAIT_STATES + 1));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_err", 32'(rsp_err), 32'(exp_err));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  sz;
    for (int i = 0; i < NBYTES; i++) model[i] = 8'h00;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = 32'd0;
    rsp_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    #1 check("rst_req_ready", 32'(req_ready), 32'd1);

    access(1'b0, 2'b10, 1'b0, 'h00, 32'd0, 0);
    access(1'b1, 2'b10, 1'b0, 'h08, 32'hDEADBEEF, 0);
    access(1'b0, 2'b10, 1'b0, 'h08, 32'd0, 0);
    access(1'b1, 2'b00, 1'b0, 'h09, 32'h00000080, 0);
    access(1'b0, 2'b00, 1'b0, 'h09, 32'd0, 0);
    access(1'b0, 2'b00, 1'b1, 'h09, 32'd0, 0);
    access(1'b0, 2'b10, 1'b0, 'h08, 32'd0, 0);
    access(1'b1, 2'b01, 1'b0, 'h0C, 32'h0000CAFE, 0);
    access(1'b1, 2'b01, 1'b0, 'h0E, 32'h00001234, 0);
    access(1'b0, 2'b10, 1'b0, 'h0C, 32'd0, 0);
    access(1'b0, 2'b10, 1'b0, 'h08, 32'd0, 5);
    access(1'b1, 2'b10, 1'b0, 'h02, 32'hA5A5A5A5, 0);
    access(1'b0, 2'b10, 1'b0, 'h00, 32'd0, 0);
    access(1'b0, 2'b01, 1'b0, 'h0F, 32'd0, 0);
    access(1'b0, 2'b11, 1'b1, 'h0B, 32'd0, 1);

    // Reset during WAIT of a store: the write must not land.
    access(1'b1, 2'b10, 1'b0, 'h10, 32'h11223344, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 7'h10;
    req_wdata = 32'h55667788;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("wait_rst_valid", 32'(rsp_valid), 32'd0);
    check("wait_rst_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("wait_rst_ready", 32'(req_ready), 32'd1);
    access(1'b0, 2'b10, 1'b0, 'h10, 32'd0, 0);

    for (int t = 0; t < 80; t++) begin
      d  = $urandom;
      sz = 2'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, NBYTES - 1)), d, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
